// File: rtl/pueo_adc_pkg.sv
// pueo_adc_pkg: shared gate FSM states and ADC container pack/unpack helpers.
package pueo_adc_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, GATE} gate_state_t;

    localparam int ADC_CONTAINER = 16;
    localparam int ADC_MAX_SAMP  = 16;
    localparam int ADC_MAX_W     = ADC_CONTAINER * ADC_MAX_SAMP;
    localparam int ADC_IDX_W     = $clog2(ADC_MAX_W);

    // Samples are MSB-justified in their containers; low bits are dropped on unpack.
    function automatic logic [ADC_MAX_W-1:0] unpack_adc(input logic [ADC_MAX_W-1:0] raw,
                                                        input int nsamp, input int nbits);
        logic [ADC_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADC_MAX_SAMP; i++)
            for (int b = 0; b < ADC_CONTAINER; b++)
                if (i < nsamp && b < nbits)
                    r[ADC_IDX_W'(i*nbits + b)] = raw[ADC_IDX_W'(ADC_CONTAINER*i + ADC_CONTAINER - nbits + b)];
        return r;
    endfunction

    function automatic logic [ADC_MAX_W-1:0] pack_adc(input logic [ADC_MAX_W-1:0] smp,
                                                      input int nsamp, input int nbits);
        logic [ADC_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADC_MAX_SAMP; i++)
            for (int b = 0; b < ADC_CONTAINER; b++)
                if (i < nsamp && b < nbits)
                    r[ADC_IDX_W'(ADC_CONTAINER*i + ADC_CONTAINER - nbits + b)] = smp[ADC_IDX_W'(i*nbits + b)];
        return r;
    endfunction

endpackage

// File: rtl/adc_capture_gate_fsm.sv
// capture_gate_fsm: trigger edge detect, delay/length counting and trigger bookkeeping.
module capture_gate_fsm
    import pueo_adc_pkg::*;
#(
    parameter int DELAY_BITS = 16,
    parameter int LEN_BITS   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  capture_i,
    input  logic [DELAY_BITS-1:0] delay_i,
    input  logic [LEN_BITS-1:0]   length_i,
    input  logic                  retrig_i,
    output logic                  gate_en,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  missed_o,
    output logic [15:0]           trig_count_o
);

    localparam int CW = DELAY_BITS > LEN_BITS ? DELAY_BITS : LEN_BITS;
    localparam logic [CW-1:0] ONE = 1;

    gate_state_t         state;
    logic                c0, c1, rise;
    logic [LEN_BITS-1:0] len_sh;
    logic [CW-1:0]       cnt;

    assign rise    = c0 & ~c1;
    assign gate_en = state == GATE;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            c0           <= 1'b0;
            c1           <= 1'b0;
            len_sh       <= '0;
            cnt          <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            missed_o     <= 1'b0;
            trig_count_o <= '0;
        end else begin
            c0       <= capture_i;
            c1       <= c0;
            done_o   <= 1'b0;
            missed_o <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    len_sh       <= length_i;
                    trig_count_o <= trig_count_o + 16'd1;
                    busy_o       <= 1'b1;
                    // D=0,L=0 takes a single DELAY cycle so done lands the cycle after acceptance
                    state        <= (delay_i == '0 && length_i != '0) ? GATE : DELAY;
                    cnt          <= delay_i != '0 ? CW'(delay_i) - ONE :
                                    length_i != '0 ? CW'(length_i) - ONE : '0;
                end
                DELAY: begin
                    missed_o <= rise;
                    if (cnt == '0) begin
                        state  <= len_sh == '0 ? IDLE : GATE;
                        cnt    <= CW'(len_sh) - ONE;
                        done_o <= len_sh == '0;
                        busy_o <= len_sh != '0;
                    end else
                        cnt <= cnt - ONE;
                end
                GATE: if (rise && retrig_i) begin
                    cnt          <= CW'(len_sh) - ONE;
                    trig_count_o <= trig_count_o + 16'd1;
                end else begin
                    missed_o <= rise;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else
                        cnt <= cnt - ONE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_gate.sv
// adc_capture_gate: triggered capture window that passes unpacked ADC beats and zeros otherwise.
module adc_capture_gate
    import pueo_adc_pkg::*;
#(
    parameter int NCHAN      = 2,
    parameter int NSAMP      = 8,
    parameter int NBITS      = 12,
    parameter int DELAY_BITS = 16,
    parameter int LEN_BITS   = 16
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 capture_i,
    input  logic [DELAY_BITS-1:0]                delay_i,
    input  logic [LEN_BITS-1:0]                  length_i,
    input  logic                                 retrig_i,
    input  logic [NCHAN*NSAMP*ADC_CONTAINER-1:0] adc_tdata,
    input  logic                                 adc_tvalid,
    output logic [NCHAN*NSAMP*NBITS-1:0]         dat_o,
    output logic                                 gate_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 missed_o,
    output logic [15:0]                          trig_count_o
);

    localparam int IW = NSAMP * ADC_CONTAINER;
    localparam int OW = NSAMP * NBITS;

    logic gate_en, pass;

    assign pass = gate_en & adc_tvalid;

    capture_gate_fsm #(
        .DELAY_BITS (DELAY_BITS),
        .LEN_BITS   (LEN_BITS)
    ) u_fsm (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .capture_i    (capture_i),
        .delay_i      (delay_i),
        .length_i     (length_i),
        .retrig_i     (retrig_i),
        .gate_en      (gate_en),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .missed_o     (missed_o),
        .trig_count_o (trig_count_o)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            gate_o <= 1'b0;
        else
            gate_o <= pass;
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic [OW-1:0] q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
                q <= '0;
            else
                q <= pass ? OW'(unpack_adc(ADC_MAX_W'(adc_tdata[c*IW +: IW]), NSAMP, NBITS)) : '0;
        end
        assign dat_o[c*OW +: OW] = q;
    end

endmodule

// File: tb/tb_adc_capture_gate.sv
// tb_adc_capture_gate: scenario and randomized checks of adc_capture_gate against a window-timeline model.
module tb_adc_capture_gate;

    localparam int NCHAN = 2;
    localparam int NSAMP = 8;
    localparam int NBITS = 12;
    localparam int IW    = NCHAN * NSAMP * 16;
    localparam int DW    = NCHAN * NSAMP * NBITS;
    localparam int VW    = 20 + DW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          capture_i = 1'b0;
    logic [15:0]   delay_i = '0;
    logic [15:0]   length_i = '0;
    logic          retrig_i = 1'b0;
    logic [IW-1:0] adc_tdata = '0;
    logic          adc_tvalid = 1'b0;
    logic [DW-1:0] dat_o;
    logic          gate_o, busy_o, done_o, missed_o;
    logic [15:0]   trig_count_o;
    logic [VW-1:0] obs, exp_vec;

    adc_capture_gate #(
        .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .DELAY_BITS(16), .LEN_BITS(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .capture_i(capture_i), .delay_i(delay_i),
        .length_i(length_i), .retrig_i(retrig_i), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
        .dat_o(dat_o), .gate_o(gate_o), .busy_o(busy_o), .done_o(done_o),
        .missed_o(missed_o), .trig_count_o(trig_count_o)
    );

    always #5 aclk = ~aclk;

    assign obs = {gate_o, done_o, missed_o, busy_o, trig_count_o, dat_o};

    int total = 0, bad = 0;
    int cyc = 0, idle_at = -1, gate_from = -1, l_sh = 0;
    logic h1 = 1'b0, h2 = 1'b0;
    logic [15:0] m_trig = '0;
    int gates, dones, misses, first_gate, last_gate, last_done, t_edge, accepted = 0;
    bit ramp = 1'b1;

    function automatic logic [DW-1:0] unpack_ref(input logic [IW-1:0] d);
        logic [DW-1:0] r;
        logic [15:0]   w;
        r = '0;
        for (int j = 0; j < NCHAN*NSAMP; j++) begin
            w = d[j*16 +: 16];
            r[j*NBITS +: NBITS] = NBITS'(w >> (16 - NBITS));
        end
        return r;
    endfunction

    task automatic clear_stats();
        gates = 0; dones = 0; misses = 0;
        first_gate = -1; last_gate = -1; last_done = -1;
    endtask

    // Model: each accepted window is a timeline [gate_from, idle_at) in edge numbers.
    task automatic step();
        int   k;
        logic rise, pg, pidle, em, eg;
        k = cyc + 1;
        if (!aresetn) begin
            h1 = 1'b0; h2 = 1'b0; idle_at = -1; gate_from = -1; m_trig = '0;
            exp_vec = '0;
        end else begin
            rise  = h1 & ~h2;
            pg    = (k-1 >= gate_from) && (k-1 < idle_at);
            pidle = (k-1 >= idle_at);
            em    = 1'b0;
            if (rise) begin
                if (pidle) begin
                    m_trig++;
                    l_sh      = int'(length_i);
                    gate_from = k + ((length_i == 0 && delay_i == 0) ? 1 : int'(delay_i));
                    idle_at   = gate_from + l_sh;
                end else if (k-1 < gate_from || !retrig_i)
                    em = 1'b1;
                else begin
                    idle_at = k + l_sh;
                    m_trig++;
                end
            end
            eg = pg & adc_tvalid;
            exp_vec = {eg, k == idle_at, em, k < idle_at, m_trig, eg ? unpack_ref(adc_tdata) : {DW{1'b0}}};
            h2 = h1;
            h1 = capture_i;
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (gate_o) begin
            gates++;
            if (first_gate < 0) first_gate = cyc;
            last_gate = cyc;
        end
        if (done_o) begin
            dones++;
            last_done = cyc;
        end
        if (missed_o) misses++;
        for (int j = 0; j < IW/16; j++)
            adc_tdata[j*16 +: 16] = ramp ? 16'(cyc*40 + j*3) : 16'($urandom);
    endtask

    task automatic idle(input int n);
        capture_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== {VW{1'b0}}) begin bad++; $display("FAIL reset_hold got=%h exp=0", obs); end
        end
        aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, exp_vec); end
        end
    endtask

    task automatic test_basic();
        delay_i = 16'd0; length_i = 16'd4; retrig_i = 1'b0; adc_tvalid = 1'b1;
        clear_stats();
        t_edge = cyc + 1;
        capture_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            capture_i = 1'b0;
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, obs, exp_vec); end
        end
        accepted += 1;
        total += 4;
        if (first_gate - t_edge !== 2) begin bad++; $display("FAIL basic_first got=%0d exp=2", first_gate - t_edge); end
        if (last_gate - t_edge !== 5) begin bad++; $display("FAIL basic_last got=%0d exp=5", last_gate - t_edge); end
        if (dones !== 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", dones); end
        if (trig_count_o !== 16'(accepted)) begin bad++; $display("FAIL basic_trig got=%0d exp=%0d", trig_count_o, accepted); end
        idle(3);
    endtask

    task automatic test_delay_shadow();
        delay_i = 16'd10; length_i = 16'd32;
        clear_stats();
        t_edge = cyc + 1;
        capture_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            capture_i = 1'b0;
            if (i == 15) begin length_i = 16'd5; delay_i = 16'd2; end
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL delay_cyc%0d got=%h exp=%h", i, obs, exp_vec); end
        end
        accepted += 1;
        total += 4;
        if (first_gate - t_edge !== 12) begin bad++; $display("FAIL delay_first got=%0d exp=12", first_gate - t_edge); end
        if (gates !== 32) begin bad++; $display("FAIL delay_beats got=%0d exp=32", gates); end
        if (dones !== 1) begin bad++; $display("FAIL delay_done got=%0d exp=1", dones); end
        if (trig_count_o !== 16'(accepted)) begin bad++; $display("FAIL delay_trig got=%0d exp=%0d", trig_count_o, accepted); end
        idle(3);
    endtask

    task automatic test_zero_len(input int d, input int done_at);
        delay_i = 16'(d); length_i = 16'd0;
        clear_stats();
        t_edge = cyc + 1;
        capture_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            capture_i = 1'b0;
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL zlen_d%0d_cyc%0d got=%h exp=%h", d, i, obs, exp_vec); end
        end
        accepted += 1;
        total += 4;
        if (gates !== 0) begin bad++; $display("FAIL zlen_d%0d_gate got=%0d exp=0", d, gates); end
        if (last_done - t_edge !== done_at) begin bad++; $display("FAIL zlen_d%0d_done_at got=%0d exp=%0d", d, last_done - t_edge, done_at); end
        if (dones !== 1) begin bad++; $display("FAIL zlen_d%0d_dones got=%0d exp=1", d, dones); end
        if (trig_count_o !== 16'(accepted)) begin bad++; $display("FAIL zlen_d%0d_trig got=%0d exp=%0d", d, trig_count_o, accepted); end
        idle(2);
    endtask

    task automatic test_retrigger(input bit rt);
        delay_i = 16'd0; length_i = 16'd8; retrig_i = rt;
        clear_stats();
        for (int i = 0; i < 25; i++) begin
            capture_i = (i == 0 || i == 5);
            step();
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL retrig%0d_cyc%0d got=%h exp=%h", rt, i, obs, exp_vec); end
        end
        capture_i = 1'b0;
        accepted += rt ? 2 : 1;
        total += 5;
        if (gates !== (rt ? 13 : 8)) begin bad++; $display("FAIL retrig%0d_beats got=%0d exp=%0d", rt, gates, rt ? 13 : 8); end
        if (last_gate - first_gate !== (rt ? 12 : 7)) begin bad++; $display("FAIL retrig%0d_span got=%0d", rt, last_gate - first_gate); end
        if (dones !== 1) begin bad++; $display("FAIL retrig%0d_done got=%0d exp=1", rt, dones); end
        if (misses !== (rt ? 0 : 1)) begin bad++; $display("FAIL retrig%0d_missed got=%0d exp=%0d", rt, misses, rt ? 0 : 1); end
        if (trig_count_o !== 16'(accepted)) begin bad++; $display("FAIL retrig%0d_trig got=%0d exp=%0d", rt, trig_count_o, accepted); end
        retrig_i = 1'b0;
        idle(2);
    endtask

    task automatic test_tvalid_gap();
        delay_i = 16'd0; length_i = 16'd16;
        clear_stats();
        t_edge = cyc + 1;
        for (int i = 0; i < 22; i++) begin
            capture_i  = (i == 0);
            adc_tvalid = !(i == 6 || i == 7);
            step();
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL gap_cyc%0d got=%h exp=%h", i, obs, exp_vec); end
        end
        adc_tvalid = 1'b1;
        accepted += 1;
        total += 3;
        if (gates !== 14) begin bad++; $display("FAIL gap_beats got=%0d exp=14", gates); end
        if (last_gate - t_edge !== 17) begin bad++; $display("FAIL gap_last got=%0d exp=17", last_gate - t_edge); end
        if (last_done - t_edge !== 17) begin bad++; $display("FAIL gap_done got=%0d exp=17", last_done - t_edge); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        delay_i = 16'd0; length_i = 16'd20;
        capture_i = 1'b1;
        step();
        capture_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (!gate_o || !busy_o) begin bad++; $display("FAIL rstmid_pre got gate=%0b busy=%0b exp=1", gate_o, busy_o); end
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (obs !== {VW{1'b0}}) begin bad++; $display("FAIL rstmid_async got=%h exp=0", obs); end
        capture_i = 1'b1;
        step();
        step();
        aresetn = 1'b1;
        accepted = 1;
        clear_stats();
        t_edge = cyc + 1;
        for (int i = 0; i < 26; i++) begin
            step();
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL rstmid_cyc%0d got=%h exp=%h", i, obs, exp_vec); end
        end
        total += 3;
        if (first_gate - t_edge !== 2) begin bad++; $display("FAIL rstmid_first got=%0d exp=2", first_gate - t_edge); end
        if (gates !== 20) begin bad++; $display("FAIL rstmid_beats got=%0d exp=20", gates); end
        if (trig_count_o !== 16'(accepted)) begin bad++; $display("FAIL rstmid_trig got=%0d exp=%0d", trig_count_o, accepted); end
        idle(3);
    endtask

    task automatic test_random();
        ramp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) capture_i = ~capture_i;
            delay_i    = 16'($urandom_range(0, 4));
            length_i   = 16'($urandom_range(0, 6));
            retrig_i   = 1'($urandom_range(0, 1));
            adc_tvalid = $urandom_range(0, 7) != 0;
            step();
            total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL random_cyc%0d got=%h exp=%h", i, obs, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay_shadow();
        test_zero_len(3, 4);
        test_zero_len(0, 2);
        test_retrigger(1'b1);
        test_retrigger(1'b0);
        test_tvalid_gap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
